// File: rtl/mixer_pkg.sv
// Shared types and constants for the tile layer mixer.
package mixer_pkg;

    localparam int PAL_DATA_W = 15;
    localparam int PIPE_DEPTH = 3;
    localparam int MAX_LAYERS = 4;

    // Field order matches the palette word layout {B, G, R}.
    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } rgb_t;

    function automatic rgb_t pal_to_rgb(input logic [PAL_DATA_W-1:0] d);
        return rgb_t'(d);
    endfunction

endpackage

// File: rtl/mixer_palette_ram.sv
// Single-port palette RAM with synchronous read and two byte-lane write enables.
module mixer_palette_ram
    import mixer_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [1:0]            be,
    input  logic [AW-1:0]         addr,
    input  logic [PAL_DATA_W-1:0] wdata,
    output logic [PAL_DATA_W-1:0] rdata
);

    logic [PAL_DATA_W-1:0] mem [0:(1<<AW)-1];

    // Read returns the pre-write contents on a same-cycle write.
    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        if (we) begin
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem[addr][14:8] <= wdata[14:8];
        end
    end

endmodule

// File: rtl/tile_layer_mixer.sv
// Priority mixer for tile layers with a shared CPU/video palette port.
// Optional MIXER_PALETTE_BYPASS_EN: EN_PALETTE=0 outputs the winning pen as grey.
module tile_layer_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int PIX_BITS   = 4,
    parameter int COL_BITS   = 4,
    parameter int PAL_AW     = 10
) (
    input  logic                           CLK_32M,
    input  logic                           reset,
    input  logic                           CE_PIX,
    input  logic [NUM_LAYERS*PIX_BITS-1:0] PIX,
    input  logic [NUM_LAYERS*COL_BITS-1:0] COL,
    input  logic [NUM_LAYERS-1:0]          CP15,
    input  logic [NUM_LAYERS-1:0]          CP8,
    input  logic [NUM_LAYERS-1:0]          LAYER_EN,
    input  logic [NUM_LAYERS*2-1:0]        PRI_ORDER,
    input  logic [PAL_AW-1:0]              A,
    input  logic [15:0]                    DIN,
    input  logic [1:0]                     BYTE_SEL,
    input  logic                           CS,
    input  logic                           MRD,
    input  logic                           MWR,
    output logic [15:0]                    DOUT,
    output logic                           DOUT_VALID,
    output logic [4:0]                     RED,
    output logic [4:0]                     GREEN,
    output logic [4:0]                     BLUE,
    output logic                           P1L,
    input  logic                           EN_PALETTE
);

    localparam int LIDX_W = (NUM_LAYERS > 2) ? 2 : 1;
    localparam int IDX_W  = LIDX_W + COL_BITS + PIX_BITS;
    localparam int STAGES = PIPE_DEPTH - 1;

    logic [STAGES:0]                         vld_pipe;
    logic [NUM_LAYERS-1:0][PIX_BITS-1:0]     s1_pix;
    logic [NUM_LAYERS-1:0][COL_BITS-1:0]     s1_col;
    logic [NUM_LAYERS-1:0][1:0]              s1_pri;
    logic [NUM_LAYERS-1:0]                   s1_en, s1_cp15, s1_cp8, opaque;
    logic                                    s2_p1l, p1l_hit;
    logic [LIDX_W-1:0]                       win_idx;
    logic [2:0]                              win_rank;
    logic [PIX_BITS-1:0]                     win_pen;
    logic [COL_BITS-1:0]                     win_col;
    logic [IDX_W+PAL_AW-1:0]                 idx_ext;
    logic [PAL_AW-1:0]                       vid_addr, ram_addr;
    logic [PAL_DATA_W-1:0]                   ram_q, vid_hold, vid_data, dout_hold;
    logic                                    vid_rd_d, serve_cpu;
    logic                                    pend, pend_wr, dout_valid;
    logic [PAL_AW-1:0]                       pend_addr;
    logic [PAL_DATA_W-1:0]                   pend_din;
    logic [1:0]                              pend_be;
    rgb_t                                    rgb_q;
    logic                                    p1l_q;
    logic                                    unused_bits;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        assign opaque[g] = s1_en[g] & (|s1_pix[g]);
    end

    // Strict '<' keeps the lowest layer index on equal ranks.
    always_comb begin
        win_idx  = '0;
        win_rank = 3'd4;
        win_pen  = '0;
        win_col  = s1_col[0];
        p1l_hit  = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (opaque[i] && ({1'b0, s1_pri[i]} < win_rank)) begin
                win_rank = {1'b0, s1_pri[i]};
                win_idx  = LIDX_W'(i);
                win_pen  = s1_pix[i];
                win_col  = s1_col[i];
            end
            if ((s1_cp15[i] && opaque[i]) ||
                (s1_cp8[i] && s1_pix[i][PIX_BITS-1] && s1_en[i]))
                p1l_hit = 1'b1;
        end
    end

    assign idx_ext   = (IDX_W+PAL_AW)'({win_idx, win_col, win_pen});
    assign vid_addr  = idx_ext[PAL_AW-1:0];
    assign serve_cpu = pend && !CE_PIX;
    assign ram_addr  = serve_cpu ? pend_addr : vid_addr;

    mixer_palette_ram #(.AW(PAL_AW)) u_pal (
        .clk   (CLK_32M),
        .we    (serve_cpu && pend_wr),
        .be    (pend_be),
        .addr  (ram_addr),
        .wdata (pend_din),
        .rdata (ram_q)
    );

    // CPU service may reuse the port before the next CE, so keep the video read.
    assign vid_data = vid_rd_d ? ram_q : vid_hold;

`ifdef MIXER_PALETTE_BYPASS_EN
    logic [PIX_BITS-1:0] s2_pen;
    logic [PIX_BITS+4:0] grey_ext;
    logic [4:0]          grey;
    assign grey_ext = {s2_pen, s2_pen[PIX_BITS-1], 4'b0};
    assign grey     = grey_ext[PIX_BITS+4 -: 5];
`endif

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            vld_pipe <= '0;
            s2_p1l   <= 1'b0;
            rgb_q    <= '0;
            p1l_q    <= 1'b1;
        end else if (CE_PIX) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            s1_pix   <= PIX;
            s1_col   <= COL;
            s1_pri   <= PRI_ORDER;
            s1_en    <= LAYER_EN;
            s1_cp15  <= CP15;
            s1_cp8   <= CP8;
            s2_p1l   <= p1l_hit;
`ifdef MIXER_PALETTE_BYPASS_EN
            s2_pen   <= win_pen;
`endif
            if (vld_pipe[STAGES-1]) begin
`ifdef MIXER_PALETTE_BYPASS_EN
                if (!EN_PALETTE) rgb_q <= '{b: grey, g: grey, r: grey};
                else             rgb_q <= pal_to_rgb(vid_data);
`else
                rgb_q <= pal_to_rgb(vid_data);
`endif
                p1l_q <= ~s2_p1l;
            end
        end
    end

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            vid_rd_d   <= 1'b0;
            vid_hold   <= '0;
            pend       <= 1'b0;
            pend_wr    <= 1'b0;
            dout_valid <= 1'b0;
            dout_hold  <= '0;
        end else begin
            vid_rd_d   <= CE_PIX;
            if (vid_rd_d) vid_hold <= ram_q;
            dout_valid <= serve_cpu && !pend_wr;
            if (dout_valid) dout_hold <= ram_q;
            if (serve_cpu) begin
                pend <= 1'b0;
            end else if (!pend && CS && (MRD || MWR)) begin
                pend      <= 1'b1;
                pend_wr   <= MWR;
                pend_addr <= A;
                pend_din  <= DIN[PAL_DATA_W-1:0];
                pend_be   <= BYTE_SEL;
            end
        end
    end

    assign DOUT        = {1'b0, dout_valid ? ram_q : dout_hold};
    assign DOUT_VALID  = dout_valid;
    assign RED         = rgb_q.r;
    assign GREEN       = rgb_q.g;
    assign BLUE        = rgb_q.b;
    assign P1L         = p1l_q;
    assign unused_bits = ^{DIN[15], EN_PALETTE, vld_pipe[STAGES]};

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Directed self-checking bench for tile_layer_mixer (default parameters).
module tb_tile_layer_mixer;

    logic        CLK_32M = 1'b0;
    logic        reset, CE_PIX;
    logic [7:0]  PIX, COL;
    logic [1:0]  CP15, CP8, LAYER_EN;
    logic [3:0]  PRI_ORDER;
    logic [9:0]  A;
    logic [15:0] DIN;
    logic [1:0]  BYTE_SEL;
    logic        CS, MRD, MWR;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic [4:0]  RED, GREEN, BLUE;
    logic        P1L, EN_PALETTE;

    int tests = 0;
    int fails = 0;

    // Palette contents {B,G,R} and their addresses {layer, col, pen}.
    localparam logic [14:0] E_BACK = {5'd1,  5'd2,  5'd3};   // 0x000
    localparam logic [14:0] E_L1   = {5'd3,  5'd7,  5'd11};  // 0x165: L1 col6 pen5
    localparam logic [14:0] E_L0   = {5'd5,  5'd9,  5'd17};  // 0x023: L0 col2 pen3
    localparam logic [14:0] E_P8   = {5'd4,  5'd4,  5'd4};   // 0x008: L0 col0 pen8
    localparam logic [14:0] E_L1B  = {5'd30, 5'd0,  5'd31};  // 0x1A5: L1 colA pen5
    localparam logic [14:0] E_PA   = {5'd6,  5'd6,  5'd6};   // 0x00A: L0 col0 penA

    tile_layer_mixer dut (
        .CLK_32M(CLK_32M), .reset(reset), .CE_PIX(CE_PIX), .PIX(PIX), .COL(COL),
        .CP15(CP15), .CP8(CP8), .LAYER_EN(LAYER_EN), .PRI_ORDER(PRI_ORDER),
        .A(A), .DIN(DIN), .BYTE_SEL(BYTE_SEL), .CS(CS), .MRD(MRD), .MWR(MWR),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .RED(RED), .GREEN(GREEN),
        .BLUE(BLUE), .P1L(P1L), .EN_PALETTE(EN_PALETTE)
    );

    always #5 CLK_32M = ~CLK_32M;

    task automatic tick();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic set_px(input logic [3:0] p0, c0, p1, c1,
                          input logic [1:0] r0, r1, en);
        PIX = {p1, p0}; COL = {c1, c0}; PRI_ORDER = {r1, r0}; LAYER_EN = en;
        CP15 = 2'b00; CP8 = 2'b00;
    endtask

    task automatic cpu_write(input logic [9:0] addr, input logic [15:0] d,
                             input logic [1:0] bs);
        CE_PIX = 1'b0; A = addr; DIN = d; BYTE_SEL = bs; CS = 1'b1; MWR = 1'b1;
        tick();
        CS = 1'b0; MWR = 1'b0;
        tick();
    endtask

    // Leaves the bench just after the service edge, where the pulse is due.
    task automatic cpu_read(input logic [9:0] addr);
        CE_PIX = 1'b0; A = addr; CS = 1'b1; MRD = 1'b1;
        tick();
        CS = 1'b0; MRD = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tests++; if ({BLUE, GREEN, RED} !== 15'h0) begin fails++;
            $display("FAIL reset_rgb got %h want 0000", {BLUE, GREEN, RED}); end
        tests++; if (P1L !== 1'b1) begin fails++;
            $display("FAIL reset_p1l got %b want 1", P1L); end
        tests++; if (DOUT !== 16'h0) begin fails++;
            $display("FAIL reset_dout got %h want 0000", DOUT); end
        tests++; if (DOUT_VALID !== 1'b0) begin fails++;
            $display("FAIL reset_dout_valid got %b want 0", DOUT_VALID); end
    endtask

    task automatic test_palette_rw();
        cpu_write(10'h010, 16'h0000, 2'b11);
        cpu_write(10'h010, 16'h7FFF, 2'b01);
        cpu_read(10'h010);
        tests++; if (DOUT_VALID !== 1'b1) begin fails++;
            $display("FAIL lane0_read_valid got %b want 1", DOUT_VALID); end
        tests++; if (DOUT !== 16'h00FF) begin fails++;
            $display("FAIL lane0_read_data got %h want 00ff", DOUT); end
        tick();
        tests++; if (DOUT_VALID !== 1'b0 || DOUT !== 16'h00FF) begin fails++;
            $display("FAIL dout_hold got v=%b d=%h want v=0 d=00ff", DOUT_VALID, DOUT); end
        cpu_write(10'h010, 16'hFFFF, 2'b10);
        cpu_read(10'h010);
        tests++; if (DOUT !== 16'h7FFF) begin fails++;
            $display("FAIL lane1_bit15 got %h want 7fff", DOUT); end
    endtask

    task automatic load_palette();
        cpu_write(10'h000, {1'b0, E_BACK}, 2'b11);
        cpu_write(10'h165, {1'b0, E_L1},   2'b11);
        cpu_write(10'h023, {1'b0, E_L0},   2'b11);
        cpu_write(10'h008, {1'b0, E_P8},   2'b11);
        cpu_write(10'h1A5, {1'b0, E_L1B},  2'b11);
        cpu_write(10'h00A, {1'b0, E_PA},   2'b11);
    endtask

    task automatic test_reset_latency();
        set_px(4'h3, 4'h2, 4'h5, 4'h6, 2'd1, 2'd0, 2'b11);
        CE_PIX = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        tests++; if ({BLUE, GREEN, RED} !== 15'h0) begin fails++;
            $display("FAIL first_valid_early got %h want 0000", {BLUE, GREEN, RED}); end
        tick();
        tests++; if ({BLUE, GREEN, RED} !== E_L1) begin fails++;
            $display("FAIL l1_front_3ce got %h want %h", {BLUE, GREEN, RED}, E_L1); end
    endtask

    task automatic test_priority();
        CE_PIX = 1'b1;
        set_px(4'h3, 4'h2, 4'h5, 4'h6, 2'd0, 2'd1, 2'b11);
        tick(); tick(); tick();
        tests++; if ({BLUE, GREEN, RED} !== E_L0) begin fails++;
            $display("FAIL l0_front got %h want %h", {BLUE, GREEN, RED}, E_L0); end
        set_px(4'h3, 4'h2, 4'h5, 4'h6, 2'd2, 2'd2, 2'b11);
        tick(); tick(); tick();
        tests++; if ({BLUE, GREEN, RED} !== E_L0) begin fails++;
            $display("FAIL rank_tie got %h want %h", {BLUE, GREEN, RED}, E_L0); end
        set_px(4'h0, 4'h2, 4'h5, 4'h6, 2'd0, 2'd1, 2'b11);
        tick(); tick(); tick();
        tests++; if ({BLUE, GREEN, RED} !== E_L1) begin fails++;
            $display("FAIL l0_transparent got %h want %h", {BLUE, GREEN, RED}, E_L1); end
        set_px(4'h0, 4'h0, 4'h5, 4'h6, 2'd1, 2'd0, 2'b01);
        tick(); tick(); tick();
        tests++; if ({BLUE, GREEN, RED} !== E_BACK || P1L !== 1'b1) begin fails++;
            $display("FAIL backdrop got rgb=%h p1l=%b want rgb=%h p1l=1",
                     {BLUE, GREEN, RED}, P1L, E_BACK); end
    endtask

    task automatic test_back_to_back();
        CE_PIX = 1'b1;
        set_px(4'h3, 4'h2, 4'h5, 4'h6, 2'd0, 2'd1, 2'b11);
        tick();
        set_px(4'h0, 4'h0, 4'h5, 4'hA, 2'd0, 2'd0, 2'b11);
        tick();
        tests++; if ({BLUE, GREEN, RED} !== E_BACK) begin fails++;
            $display("FAIL b2b_not_early got %h want %h", {BLUE, GREEN, RED}, E_BACK); end
        tick();
        tests++; if ({BLUE, GREEN, RED} !== E_L0) begin fails++;
            $display("FAIL b2b_first got %h want %h", {BLUE, GREEN, RED}, E_L0); end
        tick();
        tests++; if ({BLUE, GREEN, RED} !== E_L1B) begin fails++;
            $display("FAIL b2b_second got %h want %h", {BLUE, GREEN, RED}, E_L1B); end
    endtask

    task automatic test_p1l();
        CE_PIX = 1'b1;
        set_px(4'h3, 4'h2, 4'h0, 4'h0, 2'd0, 2'd1, 2'b11);
        tick(); tick(); tick();
        set_px(4'h8, 4'h0, 4'h0, 4'h0, 2'd0, 2'd1, 2'b11);
        CP8 = 2'b01;
        tick();
        set_px(4'h3, 4'h2, 4'h0, 4'h0, 2'd0, 2'd1, 2'b11);
        tick();
        tests++; if (P1L !== 1'b1) begin fails++;
            $display("FAIL p1l_cp8_early got %b want 1", P1L); end
        tick();
        tests++; if (P1L !== 1'b0 || {BLUE, GREEN, RED} !== E_P8) begin fails++;
            $display("FAIL p1l_cp8_aligned got p1l=%b rgb=%h want p1l=0 rgb=%h",
                     P1L, {BLUE, GREEN, RED}, E_P8); end
        tick();
        tests++; if (P1L !== 1'b1) begin fails++;
            $display("FAIL p1l_cp8_release got %b want 1", P1L); end
        set_px(4'h0, 4'h0, 4'h5, 4'h6, 2'd1, 2'd0, 2'b11);
        CP15 = 2'b10;
        tick(); tick(); tick();
        tests++; if (P1L !== 1'b0) begin fails++;
            $display("FAIL p1l_cp15 got %b want 0", P1L); end
        LAYER_EN = 2'b01;
        tick(); tick(); tick();
        tests++; if (P1L !== 1'b1) begin fails++;
            $display("FAIL p1l_cp15_disabled got %b want 1", P1L); end
        set_px(4'h7, 4'h0, 4'h0, 4'h0, 2'd0, 2'd1, 2'b11);
        CP8 = 2'b01;
        tick(); tick(); tick();
        tests++; if (P1L !== 1'b1) begin fails++;
            $display("FAIL p1l_cp8_pen_msb0 got %b want 1", P1L); end
    endtask

    task automatic test_bypass();
        logic [14:0] exp;
`ifdef MIXER_PALETTE_BYPASS_EN
        exp = {5'h15, 5'h15, 5'h15};
`else
        exp = E_PA;
`endif
        CE_PIX = 1'b1; EN_PALETTE = 1'b0;
        set_px(4'hA, 4'h0, 4'h0, 4'h0, 2'd0, 2'd1, 2'b11);
        tick(); tick(); tick();
        tests++; if ({BLUE, GREEN, RED} !== exp) begin fails++;
            $display("FAIL en_palette_off got %h want %h", {BLUE, GREEN, RED}, exp); end
        EN_PALETTE = 1'b1;
    endtask

    task automatic test_cpu_during_video();
        int pulses = 0;
        set_px(4'h3, 4'h2, 4'h5, 4'h6, 2'd1, 2'd0, 2'b11);
        CE_PIX = 1'b1; A = 10'h165; CS = 1'b1; MRD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (DOUT_VALID === 1'b1) pulses++;
        end
        tests++; if (pulses != 0) begin fails++;
            $display("FAIL read_during_ce got %0d pulses want 0", pulses); end
        CE_PIX = 1'b0; CS = 1'b0; MRD = 1'b0;
        tick();
        tests++; if (DOUT_VALID !== 1'b1 || DOUT !== {1'b0, E_L1}) begin fails++;
            $display("FAIL read_after_ce got v=%b d=%h want v=1 d=%h",
                     DOUT_VALID, DOUT, {1'b0, E_L1}); end
        tick();
        tests++; if (DOUT_VALID !== 1'b0) begin fails++;
            $display("FAIL read_single_pulse got %b want 0", DOUT_VALID); end
        tick();
        tests++; if (DOUT_VALID !== 1'b0) begin fails++;
            $display("FAIL read_no_repeat got %b want 0", DOUT_VALID); end
    endtask

    task automatic test_reset_mid_read();
        CE_PIX = 1'b0; A = 10'h023; CS = 1'b1; MRD = 1'b1;
        tick();
        CS = 1'b0; MRD = 1'b0; reset = 1'b1;
        tick();
        tests++; if (DOUT_VALID !== 1'b0 || DOUT !== 16'h0) begin fails++;
            $display("FAIL reset_mid_read got v=%b d=%h want v=0 d=0000", DOUT_VALID, DOUT); end
        reset = 1'b0;
        tick();
        tests++; if (DOUT_VALID !== 1'b0) begin fails++;
            $display("FAIL reset_drops_pending got %b want 0", DOUT_VALID); end
        tick();
        tests++; if (DOUT_VALID !== 1'b0) begin fails++;
            $display("FAIL reset_drops_pending_late got %b want 0", DOUT_VALID); end
    endtask

    initial begin
        reset = 1'b1; CE_PIX = 1'b0; EN_PALETTE = 1'b1;
        PIX = '0; COL = '0; CP15 = '0; CP8 = '0; LAYER_EN = '0; PRI_ORDER = '0;
        A = '0; DIN = '0; BYTE_SEL = '0; CS = 1'b0; MRD = 1'b0; MWR = 1'b0;
        repeat (3) tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_palette_rw();
        load_palette();
        test_reset_latency();
        test_priority();
        test_back_to_back();
        test_p1l();
        test_bypass();
        test_cpu_during_video();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
